// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
//
// Takes the branch-mux selected next PC, holds the architectural PC and
// fetches one instruction at a time over a req/ack + rvalid handshake.
// Every output is a flop; there is no combinational input-to-output path.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   next_pc             selected next PC, sampled on advance or redirect
//   redirect            taken branch/jump: kill current fetch, restart at next_pc
//   stall               hold current instruction
//   imem_req/addr       fetch request; addr stable until imem_ack
//   imem_ack            request accepted this cycle
//   imem_rvalid/rdata   one response per accepted request
//   instr/pc/pc_plus4   fetched instruction, its PC and PC+4 (mod 2^32)
//   instr_valid/ready   handshake towards decode
//   misaligned          one-cycle pulse after loading an unaligned next_pc
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        kill_q, kill_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] next_pc_al;
  logic        load;  // fetch_pc takes next_pc this cycle

  assign next_pc_al = {next_pc[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    kill_d        = kill_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = 1'b0;
    load          = 1'b0;

    case (state_q)
      IDLE: begin
        state_d    = REQ;
        imem_req_d = 1'b1;
        if (redirect) begin
          load        = 1'b1;
          imem_addr_d = next_pc_al;
        end else begin
          imem_addr_d = fetch_pc_q;
        end
      end

      REQ: begin
        // The address on the bus is left alone; only fetch_pc moves, and the
        // in-flight response is marked for discard.
        if (redirect) begin
          load   = 1'b1;
          kill_d = 1'b1;
        end
        if (imem_ack) begin
          state_d    = WAIT;
          imem_req_d = 1'b0;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            // Response dropped in the same cycle, so no kill is left pending
            // even if one was already set: only one response is ever owed.
            load        = 1'b1;
            kill_d      = 1'b0;
            state_d     = REQ;
            imem_req_d  = 1'b1;
            imem_addr_d = next_pc_al;
          end else if (kill_q) begin
            kill_d      = 1'b0;
            state_d     = REQ;
            imem_req_d  = 1'b1;
            imem_addr_d = fetch_pc_q;
          end else begin
            instr_d       = imem_rdata;
            pc_d          = fetch_pc_q;
            pc_plus4_d    = fetch_pc_q + 32'd4;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (redirect) begin
          load   = 1'b1;
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        // Redirect drops the held instruction; advance consumes it. Both
        // restart fetching at next_pc.
        if (redirect || (instr_ready && !stall)) begin
          load          = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = REQ;
          imem_req_d    = 1'b1;
          imem_addr_d   = next_pc_al;
        end
      end

      default: state_d = IDLE;
    endcase

    if (load) begin
      fetch_pc_d   = next_pc_al;
      misaligned_d = |next_pc[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      imem_addr_q   <= RESET_PC;
      instr_q       <= '0;
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
      kill_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      kill_q        <= kill_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit. A transaction-level model tracks the address
// the next delivered instruction must come from (the last next_pc loaded by
// a redirect or an advance) and a memory whose contents are a hash of the
// address; a behavioural responder supplies ack/rvalid with random latency.
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] DEAD   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] next_pc = '0;
  logic        redirect = 1'b0, stall = 1'b0, imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0, instr_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, instr, pc, pc_plus4;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect(redirect),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // reference model
  logic [31:0] target;
  bit          outstanding;
  int          rv_cnt;
  logic [31:0] resp_addr;
  bit          dead_data;
  bit          exp_mis;
  // knobs and per-step overrides (-1 = random)
  int ack_pct, rv_min, rv_max, ready_pct, stall_pct, redir_pct;
  bit seq_npc;
  int f_redir = -1, f_ready = -1, f_stall = -1, f_ack = -1;
  bit f_npc_en = 0;
  logic [31:0] f_npc;
  // previous-cycle observations
  bit p_valid, p_consume, p_redirect, p_req, p_ack;
  logic [31:0] p_pc, p_instr, p_addr;
  int idle, cyc;
  logic [31:0] acc_q[$];
  int rise_q[$];
  logic [31:0] saved;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    chk("rst_instr", instr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_misaligned", misaligned, 0);
  endtask

  // Reset is asserted mid-cycle and checked before any clock edge.
  task automatic do_reset(input bit stray);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    redirect = 0; imem_ack = 0; imem_rvalid = 0; instr_ready = 0; stall = 0;
    @(posedge clk); #1 check_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    if (stray) begin imem_rvalid = 1'b1; imem_rdata = DEAD; end
    target = RST_PC; outstanding = 0; rv_cnt = 0; exp_mis = 0; dead_data = 0;
    p_valid = 0; p_consume = 0; p_redirect = 0; p_req = 0; p_ack = 0; idle = 0;
    acc_q.delete();
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RST_PC);
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic step();
    logic [31:0] npc;
    bit rv, consume, load, acc;
    int r;
    chk("misaligned", misaligned, exp_mis);
    chk("no_dead_instr", instr_valid && (instr == DEAD), 0);
    if (instr_valid) chk("req_in_hold", imem_req, 0);
    if (imem_req) chk("one_outstanding", outstanding, 0);
    if (p_req && !p_ack) begin
      chk("req_held", imem_req, 1);
      chk("addr_stable", imem_addr, p_addr);
    end
    if (p_valid && !p_consume && !p_redirect) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", pc, p_pc);
      chk("hold_instr", instr, p_instr);
    end
    if (p_valid && (p_consume || p_redirect)) chk("drop_valid", instr_valid, 0);
    if (instr_valid && !p_valid) begin
      chk("pc", pc, target);
      chk("instr", instr, mem(target));
      chk("pc_plus4", pc_plus4, target + 32'd4);
      rise_q.push_back(cyc);
    end
    idle = instr_valid ? 0 : idle + 1;
    if (idle > 100) begin
      chk("timeout_idle_cycles", idle, 100);
      idle = 0;
    end

    if (f_npc_en) npc = f_npc;
    else if (seq_npc) npc = pc_plus4;
    else begin
      r = $urandom_range(99);
      if (r < 70)      npc = pc_plus4;
      else if (r < 85) npc = $urandom & 32'h0000_0FFF;
      else if (r < 95) npc = 32'hFFFF_FFF8 | ($urandom & 32'h7);
      else             npc = $urandom;
    end
    next_pc     = npc;
    redirect    = (f_redir >= 0) ? f_redir[0] : ($urandom_range(99) < redir_pct);
    instr_ready = (f_ready >= 0) ? f_ready[0] : ($urandom_range(99) < ready_pct);
    stall       = (f_stall >= 0) ? f_stall[0] : ($urandom_range(99) < stall_pct);
    rv          = outstanding && (rv_cnt == 0);
    imem_rvalid = rv;
    imem_rdata  = rv ? (dead_data ? DEAD : mem(resp_addr)) : $urandom;
    imem_ack    = imem_req && !outstanding &&
                  ((f_ack >= 0) ? f_ack[0] : ($urandom_range(99) < ack_pct));

    consume = instr_valid && instr_ready && !stall && !redirect;
    load    = redirect || consume;
    exp_mis = load && (npc[1:0] != 2'b00);
    if (load) target = {npc[31:2], 2'b00};
    acc = imem_req && imem_ack;
    if (acc) acc_q.push_back(imem_addr);
    p_valid = instr_valid; p_consume = consume; p_redirect = redirect;
    p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    p_pc = pc; p_instr = instr;
    if (rv) outstanding = 0;
    else if (outstanding) rv_cnt--;
    if (acc) begin
      outstanding = 1;
      resp_addr   = imem_addr;
      rv_cnt      = int'($urandom_range(rv_max, rv_min)) - 1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_until_valid(input int max);
    for (int i = 0; i < max && !instr_valid; i++) step();
    chk("got_valid", instr_valid, 1);
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max && !imem_req; i++) step();
    chk("got_req", imem_req, 1);
  endtask

  // Stop in WAIT with the response due in 3 more clocks (needs rv latency 3).
  task automatic wait_wait(input int max);
    for (int i = 0; i < max && !(outstanding && rv_cnt == 2 && !imem_req && !instr_valid); i++)
      step();
    chk("got_wait", outstanding && rv_cnt == 2 && !imem_req && !instr_valid, 1);
  endtask

  task automatic directed_knobs();
    ack_pct = 100; rv_min = 1; rv_max = 1; ready_pct = 100; stall_pct = 0;
    redir_pct = 0; seq_npc = 1;
    f_redir = -1; f_ready = -1; f_stall = -1; f_ack = -1; f_npc_en = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    directed_knobs();
    do_reset(0);

    // Back-to-back sequential fetch: 0,4,8 every 3 cycles.
    rise_q.delete();
    repeat (12) step();
    chk("seq_addr0", acc_q[0], 32'h0);
    chk("seq_addr1", acc_q[1], 32'h4);
    chk("seq_addr2", acc_q[2], 32'h8);
    chk("seq_gap1", rise_q[1] - rise_q[0], 3);
    chk("seq_gap2", rise_q[2] - rise_q[1], 3);

    // Back-pressure: ready low 5 cycles, then stall 2 cycles.
    run_until_valid(10);
    f_ready = 0;
    repeat (5) step();
    f_ready = 1; f_stall = 1;
    repeat (2) step();
    chk("held_after_stall", instr_valid, 1);
    f_stall = 0;
    step();
    chk("advanced", instr_valid, 0);
    chk("advance_req", imem_req, 1);
    f_ready = -1; f_stall = -1;

    // Redirect in WAIT; the killed response carries DEADBEEF.
    rv_min = 3; rv_max = 3;
    wait_wait(20);
    dead_data = 1;
    f_redir = 1; f_npc_en = 1; f_npc = 32'h100;
    step();
    f_redir = -1; f_npc_en = 0;
    step(); step();
    dead_data = 0;
    rv_min = 1; rv_max = 1;
    run_until_valid(20);
    chk("wait_redir_addr", acc_q[$], 32'h100);
    chk("wait_redir_pc", pc, 32'h100);

    // Redirect in REQ with ack held low 3 cycles.
    f_ack = 0;
    wait_req(20);
    saved = imem_addr;
    f_redir = 1; f_npc_en = 1; f_npc = 32'h200;
    step();
    f_redir = -1; f_npc_en = 0;
    step(); step();
    chk("req_addr_kept", imem_addr, saved);
    f_ack = -1;
    step();
    chk("old_addr_acked", acc_q[$], saved);
    run_until_valid(20);
    chk("req_redir_addr", acc_q[$], 32'h200);
    chk("req_redir_pc", pc, 32'h200);

    // Redirect coinciding with ack.
    f_ack = 0;
    wait_req(20);
    f_ack = 1; f_redir = 1; f_npc_en = 1; f_npc = 32'h300;
    step();
    f_ack = -1; f_redir = -1; f_npc_en = 0;
    run_until_valid(20);
    chk("ack_redir_addr", acc_q[$], 32'h300);
    chk("ack_redir_pc", pc, 32'h300);

    // Misaligned advance, then wrap-around at the top of memory.
    run_until_valid(10);
    f_ready = 1; f_npc_en = 1; f_npc = 32'h203;
    step();
    f_npc_en = 0;
    chk("mis_pulse", misaligned, 1);
    step();
    chk("mis_cleared", misaligned, 0);
    run_until_valid(20);
    chk("mis_addr", acc_q[$], 32'h200);
    f_npc_en = 1; f_npc = 32'hFFFF_FFFC;
    step();
    f_npc_en = 0; f_ready = -1;
    run_until_valid(20);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);

    // Randomized traffic.
    ack_pct = 60; rv_min = 1; rv_max = 4; ready_pct = 70; stall_pct = 20;
    redir_pct = 10; seq_npc = 0;
    repeat (1500) step();

    // Reset in the middle of WAIT, with a stray rvalid during IDLE.
    directed_knobs();
    rv_min = 3; rv_max = 3;
    wait_wait(50);
    do_reset(1);
    rv_min = 1; rv_max = 1;
    run_until_valid(20);
    chk("post_rst_addr", acc_q[0], RST_PC);
    chk("post_rst_pc", pc, RST_PC);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer. It sits directly downstream of the branch-select mux. It consumes the selected next-PC, holds the architectural PC, and fetches the instruction from instruction memory over a request/response handshake. It presents the fetched instruction, its PC, and PC+4 to decode; PC+4 also feeds the add4 input of the branch-select mux.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (must be word aligned)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous and active-low
next_pc  input  32  selected next PC from the branch mux; sampled on advance or redirect
redirect  input  1  taken branch/jump; kill current fetch, restart at next_pc
stall  input  1  hold current instruction; no advance
imem_req  output  1  fetch request
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0
imem_ack  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid, exactly one per accepted request
imem_rdata  input  32  instruction word
instr  output  32  fetched instruction
instr_valid  output  1  instr/pc valid for decode
instr_ready  input  1  decode accepts instr this cycle
pc  output  32  PC of instr
pc_plus4  output  32  pc + 4, modulo 2^32
misaligned  output  1  one-cycle pulse: loaded next_pc had bits[1:0] != 0

Behaviour:
- Reset (rst_n=0, async) drives the following:
  - Outputs: imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, pc_plus4=RESET_PC+4, instr=0, instr_valid=0, misaligned=0.
  - Internal: fetch_pc=RESET_PC, kill=0, state=IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD. Registered outputs only; no combinational path from inputs to outputs.
- IDLE: one cycle after reset release, then REQ.
- REQ: imem_req=1, imem_addr=fetch_pc.
  - On imem_ack=1: go to WAIT; imem_req drops the next cycle.
- WAIT: imem_req=0.
  - On imem_rvalid=1 with kill=0: instr<=imem_rdata, pc<=fetch_pc, pc_plus4<=fetch_pc+4, instr_valid<=1, go to HOLD.
  - On imem_rvalid=1 with kill=1: discard data, clear kill, go to REQ.
- HOLD: instr_valid=1. instr, pc, pc_plus4 are held stable.
  - Advance on instr_ready=1 and stall=0: fetch_pc<=next_pc aligned, instr_valid<=0, go to REQ.
  - instr_ready=0 or stall=1: stay in HOLD.
- Redirect rules (redirect has priority over stall and instr_ready):
  - In HOLD: fetch_pc<=next_pc aligned, instr_valid<=0, go to REQ. The held instruction is dropped, not consumed.
  - In REQ, ack=0: request address stays unchanged until ack. Load fetch_pc<=next_pc aligned, set kill. After ack go to WAIT, discard the response, then REQ at the new fetch_pc.
  - In REQ, ack=1 simultaneously: same as above (kill set, old response discarded).
  - In WAIT, rvalid=0: load fetch_pc, set kill.
  - In WAIT, rvalid=1 simultaneously: discard data, go directly to REQ at the new address, kill stays 0.
  - Second redirect while kill=1: fetch_pc is overwritten, only one response is discarded, last redirect wins.
  - In IDLE: fetch_pc<=next_pc aligned, then REQ.
- Alignment: any load from next_pc uses {next_pc[31:2],2'b00}. If next_pc[1:0]!=0, misaligned=1 for exactly the following cycle.
- Wrap-around: fetch_pc 32'hFFFF_FFFC gives pc_plus4=32'h0000_0000. No overflow flag.
- Throughput:
  - Minimum 3 cycles per instruction (REQ with immediate ack, WAIT with rvalid next cycle, HOLD with immediate ready).
  - At most one outstanding memory request.
- Reset mid-operation: everything returns to reset values immediately. A late imem_rvalid arriving in IDLE/REQ is ignored.

Test Plan:
- Reset, RESET_PC=0, memory ack=1 same cycle, rvalid 1 cycle later, next_pc=pc_plus4, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_valid pulses every 3 cycles; pc_plus4=pc+4 each time.
- Hold instr_ready=0 for 5 cycles in HOLD, then stall=1 for 2 cycles -> instr, pc, instr_valid stable; imem_req=0 throughout; advance only when ready=1 and stall=0.
- redirect=1, next_pc=0x100 while in WAIT; rvalid arrives 2 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears on instr with instr_valid; next request addr=0x100; instr delivered with pc=0x100.
- redirect in REQ with ack held 0 for 3 cycles -> imem_addr keeps old value until ack; response discarded; next request at redirect target. Repeat with redirect coinciding with ack.
- next_pc=0x203 on advance -> imem_addr=0x200, misaligned=1 for one cycle; fetch_pc=0xFFFF_FFFC -> pc_plus4=0x0.
- Assert rst_n=0 mid-WAIT, then release -> outputs at reset values asynchronously; a stray rvalid during IDLE is ignored; first request addr=RESET_PC.
